// File: rtl/program_loader.sv
// Boot-time program loader.
// Accepts a byte stream (16-bit big-endian word count followed by big-endian
// 32-bit words) and writes each word to instruction/data memory starting at
// address 0. Once the whole image is written, cpu_run releases the CPU.
// An oversized image latches err and the CPU is never released.
module program_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              err
);

   // Memory capacity in words, kept at 17 bits so it compares directly with the 16-bit count.
   localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_e;

   state_e              state_q, state_d;
   logic [15:0]         len_q, len_d;
   logic [ADDR_W:0]     word_idx_q, word_idx_d;
   logic [1:0]          byte_idx_q, byte_idx_d;
   logic [23:0]         shift_q, shift_d;

   logic                rx_ready_q, rx_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                cpu_run_q, cpu_run_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;

   logic                xfer_s;
   logic [15:0]         len_full_s;
   logic [16:0]         next_idx_s;
   logic                last_word_s;

   // A byte moves only when the loader advertises ready and the source offers one.
   assign xfer_s      = rx_valid & rx_ready_q;
   // Full count as seen while the low byte is on the bus.
   assign len_full_s  = {len_q[15:8], rx_data};
   // word_idx carries one extra bit, so a full-depth image never wraps.
   assign next_idx_s  = 17'(word_idx_q) + 17'd1;
   assign last_word_s = (next_idx_s == {1'b0, len_q});

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic of the load sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_LEN_HI;
            else       state_d = S_IDLE;
         end
         S_LEN_HI: begin
            if (xfer_s) state_d = S_LEN_LO;
            else        state_d = S_LEN_HI;
         end
         S_LEN_LO: begin
            if (!xfer_s)                          state_d = S_LEN_LO;
            else if (len_full_s == 16'd0)         state_d = S_DONE;
            else if ({1'b0, len_full_s} > DEPTH)  state_d = S_ERROR;
            else                                  state_d = S_DATA;
         end
         S_DATA: begin
            if (xfer_s && (byte_idx_q == 2'd3)) state_d = S_WRITE;
            else                                state_d = S_DATA;
         end
         S_WRITE: begin
            if (last_word_s) state_d = S_DONE;
            else             state_d = S_DATA;
         end
         S_DONE:  state_d = S_DONE;
         S_ERROR: state_d = S_ERROR;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath updates: length capture, byte assembly and word counting.
   always_comb begin
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      case (state_q)
         S_LEN_HI: begin
            if (xfer_s) len_d[15:8] = rx_data;
            else        len_d = len_q;
         end
         S_LEN_LO: begin
            if (xfer_s) len_d[7:0] = rx_data;
            else        len_d = len_q;
         end
         S_DATA: begin
            if (xfer_s) begin
               // Two-bit counter wraps 3 -> 0 on the fourth byte.
               shift_d    = {shift_q[15:0], rx_data};
               byte_idx_d = byte_idx_q + 2'd1;
            end else begin
               shift_d    = shift_q;
               byte_idx_d = byte_idx_q;
            end
         end
         S_WRITE: begin
            if (!last_word_s) word_idx_d = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
            else              word_idx_d = word_idx_q;
         end
         default: begin
            len_d = len_q;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         len_q      <= 16'd0;
         word_idx_q <= '0;
         byte_idx_q <= 2'd0;
         shift_q    <= 24'd0;
      end else begin
         len_q      <= len_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
      end
   end

   // Output decode from the upcoming state, so every output leaves a flop.
   always_comb begin
      rx_ready_d  = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_run_d   = 1'b0;
      busy_d      = 1'b0;
      err_d       = 1'b0;
      case (state_d)
         S_LEN_HI, S_LEN_LO, S_DATA: begin
            rx_ready_d = 1'b1;
            busy_d     = 1'b1;
         end
         S_WRITE: begin
            // Entered only from DATA on the fourth byte, which is still on the bus.
            mem_we_d    = 1'b1;
            busy_d      = 1'b1;
            mem_addr_d  = word_idx_q[ADDR_W-1:0];
            mem_wdata_d = {shift_q, rx_data};
         end
         S_DONE:  cpu_run_d = 1'b1;
         S_ERROR: err_d     = 1'b1;
         default: busy_d    = 1'b0;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         cpu_run_q   <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         rx_ready_q  <= rx_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_run_q   <= cpu_run_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign rx_ready  = rx_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_run   = cpu_run_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: a randomized byte-stream driver, a reference
// model that derives the expected memory writes from the stream, and a
// scoreboard monitor that checks every write strobe.
module tb_program_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_run;
   logic              busy;
   logic              err;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  mon_en   = 1'b0;
   wr_t sb[$];
   wr_t mon_e;

   program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_run(cpu_run), .busy(busy), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: expected writes are the complete words present in the stream, up to the count.
   task automatic expect_stream(input bq_t s);
      int len;
      int nw;
      len = {s[0], s[1]};
      if (len == 0 || len > DEPTH) return;
      nw = (s.size() - 2) / 4;
      if (nw > len) nw = len;
      for (int w = 0; w < nw; w++) begin
         wr_t e;
         e.addr = w[7:0];
         e.data = {s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]};
         sb.push_back(e);
      end
   endtask

   // Scoreboard monitor: every write strobe must match the next expected write.
   always @(negedge clk) begin
      if (mon_en && mem_we === 1'b1) begin
         chk("we_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
            chk("wr_data", mem_wdata, mon_e.data);
         end
         chk("ready_in_write", 32'(rx_ready), 32'd0);
         chk("run_in_write", 32'(cpu_run), 32'd0);
         chk("busy_in_write", 32'(busy), 32'd1);
      end
   end

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b0;
      rx_valid = 1'b0;
      start = 1'b0;
      repeat (cycles) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // mode 0: rx_valid always 1; mode 1: toggles every cycle; mode 2: random.
   task automatic send(input bq_t s, input int mode);
      int  i = 0;
      int  budget = 0;
      int  pend = 0;
      int  len;
      bit  tog = 1'b1;
      bit  v;
      len = {s[0], s[1]};
      while (i < s.size() && budget < 20000) begin
         @(negedge clk);
         if (pend > 0) begin
            pend--;
            if (pend == 0) chk("strobe_latency", 32'(mem_we), 32'd1);
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = tog;
            default: v = ($urandom_range(99) < 60);
         endcase
         tog = ~tog;
         if (v) begin
            rx_valid = 1'b1;
            rx_data  = s[i];
            if (rx_ready) begin
               if (i >= 5 && ((i - 2) % 4) == 3 && ((i - 2) / 4) < len && len <= DEPTH) pend = 1;
               i++;
            end
         end else begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end
         budget++;
      end
      if (i < s.size()) chk("send_timeout", 32'(i), 32'(s.size()));
      @(negedge clk);
      rx_valid = 1'b0;
      if (pend > 0) chk("strobe_latency", 32'(mem_we), 32'd1);
   endtask

   task automatic wait_drain();
      int b = 0;
      while (sb.size() != 0 && b < 50) begin
         @(negedge clk);
         b++;
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic check_end(input logic exp_run, input logic exp_err);
      @(negedge clk);
      chk("cpu_run", 32'(cpu_run), 32'(exp_run));
      chk("err", 32'(err), 32'(exp_err));
      chk("busy_idle", 32'(busy), 32'd0);
      chk("ready_end", 32'(rx_ready), 32'd0);
      chk("we_end", 32'(mem_we), 32'd0);
   endtask

   // Start a pulse and offer bytes in a terminal state; nothing may be consumed or written.
   task automatic poke_terminal(input logic exp_run, input logic exp_err);
      do_start();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
         if (rx_ready !== 1'b0) chk("terminal_ready", 32'(rx_ready), 32'd0);
      end
      rx_valid = 1'b0;
      check_end(exp_run, exp_err);
   endtask

   task automatic run_load(input bq_t s, input int mode, input logic exp_run, input logic exp_err);
      do_start();
      expect_stream(s);
      send(s, mode);
      wait_drain();
      check_end(exp_run, exp_err);
   endtask

   initial begin
      bq_t s;
      int  len;
      reset    = 1'b0;
      start    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'd0;

      // 1. Reset held low with start asserted: everything stays zero.
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", 32'(rx_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      start  = 1'b0;
      reset  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // 2. Two-word image, rx_valid always high.
      s = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
      run_load(s, 0, 1'b1, 1'b0);
      chk("hold_addr", 32'(mem_addr), 32'd1);
      chk("hold_data", mem_wdata, 32'h01234567);

      // 3. Same image with rx_valid toggling every cycle.
      do_reset(2);
      run_load(s, 1, 1'b1, 1'b0);

      // 4a. Count one past capacity: error, no writes, stays put.
      do_reset(2);
      s = '{8'h01, 8'h01};
      run_load(s, 0, 1'b0, 1'b1);
      poke_terminal(1'b0, 1'b1);

      // 4b. Exactly full memory: 256 writes, last at FF.
      do_reset(2);
      s = '{8'h01, 8'h00};
      for (int k = 0; k < 4 * DEPTH; k++) s.push_back(8'($urandom));
      run_load(s, 0, 1'b1, 1'b0);
      chk("full_last_addr", 32'(mem_addr), 32'hFF);

      // 5. Zero-length image: done at once, later traffic ignored.
      do_reset(2);
      s = '{8'h00, 8'h00};
      run_load(s, 0, 1'b1, 1'b0);
      poke_terminal(1'b1, 1'b0);

      // 6. Reset after 6 of 8 data bytes, then a fresh single-word load.
      do_reset(2);
      s = '{8'h00, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
      do_start();
      expect_stream(s);
      send(s, 0);
      wait_drain();
      do_reset(1);
      @(negedge clk);
      chk("abort_cpu_run", 32'(cpu_run), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(s, 0, 1'b1, 1'b0);
      chk("reload_data", mem_wdata, 32'h11223344);

      // Random images with random rx_valid gaps.
      for (int r = 0; r < 6; r++) begin
         do_reset(2);
         len = $urandom_range(1, 7);
         s = '{8'h00, 8'(len)};
         for (int k = 0; k < 4 * len; k++) s.push_back(8'($urandom));
         run_load(s, 2, 1'b1, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
